// File: rtl/led_mode_drv.sv
// LED pattern driver: turns the 2-bit key mode into off / on / blink / running-light patterns.
// Define LED_BREATH_EN to replace the mode-2 blink with a PWM breathing effect.
module led_mode_drv #(
   parameter int LED_NUM    = 4,
   parameter int TICK_CNT   = 12_500_000,
   parameter int BREATH_DIV = 50_000
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [1:0]         mode,
   output logic [LED_NUM-1:0] led,
   output logic               step
);

   localparam int            CW        = (TICK_CNT > 1) ? $clog2(TICK_CNT) : 1;
   localparam logic [CW-1:0] TICK_LAST = CW'(TICK_CNT - 1);

   localparam logic [1:0] MODE_OFF   = 2'd0;
   localparam logic [1:0] MODE_ON    = 2'd1;
   localparam logic [1:0] MODE_BLINK = 2'd2;
   localparam logic [1:0] MODE_RUN   = 2'd3;

   logic [1:0]    mode_r;
   logic [CW-1:0] tick_cnt;
   logic          mode_chg;
   logic          tick;

   assign mode_chg = (mode != mode_r);
   assign tick     = (tick_cnt == TICK_LAST) && !mode_chg;

   // Pattern each mode starts from when it is entered
   function automatic logic [LED_NUM-1:0] init_pattern(input logic [1:0] m);
      logic [LED_NUM-1:0] p;
      p = '0;
      case (m)
         MODE_ON:    p = '1;
`ifdef LED_BREATH_EN
         MODE_BLINK: p = '0;
`else
         MODE_BLINK: p = '1;
`endif
         MODE_RUN:   p[0] = 1'b1;
         default:    p = '0;
      endcase
      return p;
   endfunction

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mode_r <= MODE_OFF;
      end else begin
         mode_r <= mode;
      end
   end

   // A mode change restarts the step period so a new pattern always gets a full step
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tick_cnt <= '0;
      end else if (mode_chg || (tick_cnt == TICK_LAST)) begin
         tick_cnt <= '0;
      end else begin
         tick_cnt <= tick_cnt + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         step <= 1'b0;
      end else begin
         step <= tick;
      end
   end

`ifdef LED_BREATH_EN
   localparam int            DW       = (BREATH_DIV > 1) ? $clog2(BREATH_DIV) : 1;
   localparam logic [DW-1:0] DIV_LAST = DW'(BREATH_DIV - 1);

   logic [7:0]    pwm_cnt;
   logic [7:0]    duty;
   logic          dir_up;
   logic [DW-1:0] div_cnt;

   // Duty follows a 0..255..0 triangle; entering mode 2 restarts it from dark
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pwm_cnt <= '0;
         duty    <= '0;
         dir_up  <= 1'b1;
         div_cnt <= '0;
      end else if (mode_chg && (mode == MODE_BLINK)) begin
         pwm_cnt <= '0;
         duty    <= '0;
         dir_up  <= 1'b1;
         div_cnt <= '0;
      end else begin
         pwm_cnt <= pwm_cnt + 8'd1;
         if (div_cnt == DIV_LAST) begin
            div_cnt <= '0;
            if (dir_up) begin
               if (duty == 8'hFF) begin
                  dir_up <= 1'b0;
                  duty   <= 8'hFE;
               end else begin
                  duty <= duty + 8'd1;
               end
            end else begin
               if (duty == 8'h00) begin
                  dir_up <= 1'b1;
                  duty   <= 8'h01;
               end else begin
                  duty <= duty - 8'd1;
               end
            end
         end else begin
            div_cnt <= div_cnt + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         led <= '0;
      end else if (mode_chg) begin
         led <= init_pattern(mode);
      end else if (mode_r == MODE_BLINK) begin
         led <= (pwm_cnt < duty) ? '1 : '0;
      end else if (tick && (mode_r == MODE_RUN)) begin
         led <= {led[LED_NUM-2:0], led[LED_NUM-1]};
      end
   end
`else
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         led <= '0;
      end else if (mode_chg) begin
         led <= init_pattern(mode);
      end else if (tick) begin
         case (mode_r)
            MODE_BLINK: led <= ~led;
            MODE_RUN:   led <= {led[LED_NUM-2:0], led[LED_NUM-1]};
            default:    led <= init_pattern(mode_r);
         endcase
      end
   end
`endif

endmodule

// File: tb/tb_led_mode_drv.sv
// Self-checking bench for led_mode_drv: a press-count model pushes expected led/step
// per cycle into a queue, which is popped and compared after each clock edge.
module tb_led_mode_drv;

   localparam int LED_NUM    = 4;
   localparam int TICK_CNT   = 4;
   localparam int BREATH_DIV = 2;

   logic               clk = 1'b0;
   logic               rst_n;
   logic [1:0]         mode;
   logic [LED_NUM-1:0] led;
   logic               step;

   int test_count = 0;
   int fail_count = 0;

   logic [LED_NUM:0] exp_q[$];
   logic [1:0]       mdl_mode;
   int               mdl_cnt;
   int               mdl_ticks;

   led_mode_drv #(
      .LED_NUM   (LED_NUM),
      .TICK_CNT  (TICK_CNT),
      .BREATH_DIV(BREATH_DIV)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .mode (mode),
      .led  (led),
      .step (step)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      test_count++;
      if (observed !== expected) begin
         fail_count++;
         $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
      end
   endtask

   // Expected LEDs depend only on the current mode and how many steps it has taken
   function automatic logic [LED_NUM-1:0] model_led();
      logic [LED_NUM-1:0] p;
      p = '0;
      case (mdl_mode)
         2'd1: p = '1;
         2'd2: p = (mdl_ticks % 2 == 0) ? '1 : '0;
         2'd3: p[mdl_ticks % LED_NUM] = 1'b1;
         default: p = '0;
      endcase
      return p;
   endfunction

   task automatic model_reset();
      mdl_mode  = 2'd0;
      mdl_cnt   = 0;
      mdl_ticks = 0;
   endtask

   task automatic applyStimulus(input logic [1:0] m, input string tag);
      logic             mdl_step;
      logic [LED_NUM:0] exp_v;
      mode = m;
      if (m != mdl_mode) begin
         mdl_cnt   = 0;
         mdl_ticks = 0;
         mdl_step  = 1'b0;
      end else if (mdl_cnt == TICK_CNT - 1) begin
         mdl_cnt   = 0;
         mdl_ticks = mdl_ticks + 1;
         mdl_step  = 1'b1;
      end else begin
         mdl_cnt  = mdl_cnt + 1;
         mdl_step = 1'b0;
      end
      mdl_mode = m;
      exp_q.push_back({model_led(), mdl_step});
      @(posedge clk);
      #1;
      exp_v = exp_q.pop_front();
      checkOutput({tag, "_led"}, 32'(led), 32'(exp_v[LED_NUM:1]));
      checkOutput({tag, "_step"}, 32'(step), 32'(exp_v[0]));
   endtask

   initial begin
      #1_000_000;
      $display("[TB] FAIL timeout: simulation did not finish, expected completion");
      $fatal(1, "[TB] timeout");
   end

   initial begin
      rst_n = 1'b0;
      mode  = 2'd0;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      checkOutput("reset_led", 32'(led), 32'd0);
      checkOutput("reset_step", 32'(step), 32'd0);
      rst_n = 1'b1;

      for (int i = 0; i < TICK_CNT - 1; i++) applyStimulus(2'd0, "off");
      for (int i = 0; i < 21; i++) applyStimulus(2'd1, "on");
      for (int i = 0; i < 20; i++) applyStimulus(2'd3, "run");
      for (int i = 0; i < 10; i++) applyStimulus(2'd2, "blink");

      // Land the switch to mode 3 exactly on the edge where a blink step is due
      for (int i = 0; i < TICK_CNT && mdl_cnt != TICK_CNT - 1; i++) applyStimulus(2'd2, "blink_sync");
      applyStimulus(2'd3, "collide");
      for (int i = 0; i < 9; i++) applyStimulus(2'd3, "after_collide");

      for (int i = 0; i < 10; i++) applyStimulus(((i / 2) % 2 == 0) ? 2'd2 : 2'd3, "toggle");

      for (int i = 0; i < 12; i++) applyStimulus(2'd3, "run2");
      rst_n = 1'b0;
      #2;
      checkOutput("async_reset_led", 32'(led), 32'd0);
      checkOutput("async_reset_step", 32'(step), 32'd0);
      mode = 2'd0;
      model_reset();
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      for (int blk = 0; blk < 15; blk++) begin
         logic [1:0] m;
         int         len;
         m   = 2'($urandom_range(0, 3));
         len = $urandom_range(1, 10);
         for (int i = 0; i < len; i++) applyStimulus(m, "random");
      end

      $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
      $finish;
   end

endmodule
